// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - command/response wrapper that drives a combinational ALU and queues its results
//
// Accepts {a, b, opcode, mode} on a valid/ready command stream. Each accepted command is
// registered onto the ALU inputs. The inputs are held for SETTLE_CYCLES edges. The ALU result
// and flags are then captured into a first-word-fall-through response FIFO. A valid/ready
// response stream drains that FIFO.
//
// Parameters: SETTLE_CYCLES (>=1) edges the ALU inputs are held before capture,
//             RSP_DEPTH (power of two, >=2) response FIFO entries.
// Ports:      clk, rst_n (synchronous, active low)
//             cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_opcode/cmd_mode   command stream
//             alu_a/alu_b/alu_opcode/alu_mode                         registered ALU drive
//             alu_out/alu_flags {za,zb,eq,gt,lt}                      ALU result inputs
//             rsp_valid/rsp_ready/rsp_data/rsp_flags                  response stream
//             busy                                                    op in flight or FIFO non-empty
// Optional:   ALU_RSP_TAG_EN adds cmd_tag/rsp_tag (4 bits). The tag travels with its response.
module alu_cmd_responder #(
    parameter int SETTLE_CYCLES = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [2:0]  cmd_opcode,
    input  logic        cmd_mode,
`ifdef ALU_RSP_TAG_EN
    input  logic [3:0]  cmd_tag,
    output logic [3:0]  rsp_tag,
`endif
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_mode,
    input  logic [31:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        busy
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(RSP_DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_data  [RSP_DEPTH];
    logic [4:0]    mem_flags [RSP_DEPTH];
    logic          accept, push, pop;

`ifdef ALU_RSP_TAG_EN
    logic [3:0]    tag_q;
    logic [3:0]    mem_tag [RSP_DEPTH];
`endif

    // A FIFO slot is reserved at accept time. The capture in DRIVE therefore always finds room.
    assign cmd_ready = rst_n && (state == IDLE) && (count < DEPTH_C);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state != IDLE) || (count != '0);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == '0) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_mode   <= 1'b0;
            settle_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
`ifdef ALU_RSP_TAG_EN
            tag_q      <= '0;
`endif
        end else begin
            // The alu_* registers keep the last operands after capture, so the ALU outputs stay quiet.
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_opcode;
                alu_mode   <= cmd_mode;
                settle_cnt <= SETTLE_INIT;
`ifdef ALU_RSP_TAG_EN
                tag_q      <= cmd_tag;
`endif
            end else if (state == DRIVE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            // RSP_DEPTH is a power of two. The pointers therefore wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The storage needs no reset. The head is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= alu_out;
            mem_flags[wr_ptr] <= alu_flags;
`ifdef ALU_RSP_TAG_EN
            mem_tag[wr_ptr]   <= tag_q;
`endif
        end
    end

    assign rsp_data  = rsp_valid ? mem_data[rd_ptr]  : '0;
    assign rsp_flags = rsp_valid ? mem_flags[rd_ptr] : '0;
`ifdef ALU_RSP_TAG_EN
    assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]   : '0;
`endif

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - scoreboard bench for alu_cmd_responder with a stub compare ALU
module tb_alu_cmd_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [2:0]  cmd_opcode;
    logic        cmd_mode;
    logic [3:0]  cur_tag;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_mode;
    logic [31:0] alu_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        busy;
`ifdef ALU_RSP_TAG_EN
    logic [3:0]  rsp_tag;
`endif

    int tests = 0;
    int fails = 0;
    logic rand_en;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Stub ALU: the result concatenates the operands. The flags come from a real compare.
    assign alu_out   = {alu_a, alu_b};
    assign alu_flags = {alu_a == 16'd0, alu_b == 16'd0, alu_a == alu_b, alu_a > alu_b, alu_a < alu_b};

    alu_cmd_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_opcode (cmd_opcode),
        .cmd_mode   (cmd_mode),
`ifdef ALU_RSP_TAG_EN
        .cmd_tag    (cur_tag),
        .rsp_tag    (rsp_tag),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_mode   (alu_mode),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        exp_t e;
        e.data  = {a, b};
        e.flags = 5'b0;
        if (a == 0) e.flags[4] = 1'b1;
        if (b == 0) e.flags[3] = 1'b1;
        if (a == b) e.flags[2] = 1'b1;
        else if (a > b) e.flags[1] = 1'b1;
        else e.flags[0] = 1'b1;
        e.tag = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Called at posedge+1. It returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic m, input logic [3:0] t);
        bit ok = 0;
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_mode = m; cur_tag = t;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic drain();
        bit done = 0;
        rand_en = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        chk("drain_empty", 32'(done), 32'd1);
    endtask

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 2));
        return 16'($urandom);
    endfunction

    initial begin
        exp_t e;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_a = 16'h1111; cmd_b = 16'h2222;
        cmd_opcode = 3'd5; cmd_mode = 1'b1; cur_tag = 4'h0;
        rsp_ready = 1'b0; rand_en = 1'b0;

        fork
            // Monitor. It records each accept and checks each pop.
            // Handshakes sampled at negedge complete on the following posedge.
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cur_tag));
                    if (rsp_valid && rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp_data", rsp_data, e.data);
                            chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
`ifdef ALU_RSP_TAG_EN
                            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
`endif
                        end
                    end
                end
            end
            forever begin
                @(posedge clk); #1;
                if (rand_en) rsp_ready = 1'($urandom_range(0, 1));
            end
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset with cmd_valid held high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_opmode", 32'({alu_opcode, alu_mode}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; cmd_valid = 1'b0;

        // Single op latency.
        cmd_a = 16'h0001; cmd_b = 16'h0010; cmd_opcode = 3'b000; cmd_mode = 1'b0; cur_tag = 4'h3;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("drive_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("drive_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("drive_alu_ab", {alu_a, alu_b}, 32'h0001_0010);
        chk("drive_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_rsp_data", rsp_data, 32'h0001_0010);
        chk("lat_rsp_flags", 32'(rsp_flags), 32'(5'b00001));
        chk("after_cap_ready", 32'(cmd_ready), 32'd1);
        chk("hold_alu_ab", {alu_a, alu_b}, 32'h0001_0010);
        @(posedge clk); #1;
        send(16'h00E9, 16'h00E9, 3'b111, 1'b1, 4'hA);
        drain();

        // Fill the FIFO. The fifth op must wait for a pop.
        for (int i = 0; i < 4; i++) send(rnd16(), rnd16(), 3'($urandom), 1'($urandom), 4'(i));
        @(posedge clk); #1;
        cmd_a = 16'hBEEF; cmd_b = 16'h0042; cur_tag = 4'h5; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // Simultaneous push and pop with one entry queued.
        send(16'h1234, 16'h5678, 3'd2, 1'b0, 4'h7);
        @(posedge clk); #1;
        send(16'h0000, 16'h0000, 3'd1, 1'b1, 4'h8);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_valid", 32'(rsp_valid), 32'd1);
        chk("pushpop_data", rsp_data, 32'h0000_0000);
        chk("pushpop_flags", 32'(rsp_flags), 32'(5'b11100));
        @(posedge clk); #1;
        drain();

        // Reset while an op is in DRIVE with two entries queued.
        send(16'h0003, 16'h0004, 3'd3, 1'b0, 4'h3);
        send(16'h000A, 16'h0009, 3'd4, 1'b1, 4'hA);
        @(posedge clk); #1;
        send(16'h0005, 16'h0005, 3'd6, 1'b0, 4'hC);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_rsp_data", rsp_data, 32'd0);
        chk("rstmid_alu_ab", {alu_a, alu_b}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ready_back", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Random traffic with random consumer backpressure.
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rnd16(), rnd16(), 3'($urandom), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
        drain();
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
